// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch unit
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int FIFO_DEPTH_DEF = 2;
   typedef enum logic {BOOT, RUN} state_e;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, inst} buffer with push, pop, flush and occupancy count
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  fetch_entry_t  data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o
);
   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   // entry storage; contents need no reset because the count gates visibility
   always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= data_i;
   // pointers and occupancy; a flush empties the buffer like a reset
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end
   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: SRAM instruction fetch with buffered decode handoff; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit import fetch_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int              FIFO_DEPTH = FIFO_DEPTH_DEF
)(
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] im_addr,
   output logic            im_cs,
   input  logic [XLEN-1:0] inst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_inst,
   output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] perf_fetched,
   output logic [XLEN-1:0] perf_stall
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_e          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q;
   logic            inflight_q, pop, push;
   logic [CW-1:0]   count;
   logic [CW:0]     occ;
   fetch_entry_t    head, push_data;
   assign pop       = if_valid && if_ready;
   assign push      = inflight_q && !redirect_valid;
   assign push_data = {inflight_pc_q, inst};
   assign occ       = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign im_addr   = fetch_pc_q;
   // next state, issue decision (room for the response after this cycle's pop) and fetch pointer
   always_comb begin
      state_d    = (state_q == BOOT) ? RUN : state_q;
      im_cs      = (state_q == RUN) && !rst && !redirect_valid && (occ < (CW+1)'(FIFO_DEPTH));
      fetch_pc_d = redirect_valid ? (redirect_pc & {{(XLEN-2){1'b1}}, 2'b00}) :
                   im_cs ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
   end
   // state, fetch pointer and the single outstanding SRAM request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= im_cs;
         inflight_pc_q <= fetch_pc_q;
      end
   end
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .head_o  (head),
      .count_o (count)
   );
   assign if_valid = count != '0;
   assign if_pc    = if_valid ? head.pc : '0;
   assign if_inst  = if_valid ? head.inst : '0;
`ifdef FETCH_PERF_CNT_EN
   // accepted instructions and cycles where decode waited on an empty buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         perf_fetched <= perf_fetched + XLEN'(pop);
         perf_stall   <= perf_stall + XLEN'(if_ready && !if_valid);
      end
   end
`endif
endmodule
